// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - decode, writeback and ALU-operand bundle for ex_operand_stage
//
// Parameter:
//   CNT_W         width of the stall counter
// Signals (slave = the operand stage, master = the surrounding pipeline):
//   in_*          decoded instruction from decode, in_valid/in_ready handshake
//   flush         synchronous squash
//   mem_*         EX/MEM writeback info (mem_wr_en implies that stage is valid)
//   wb_*          MEM/WB writeback info
//   out_valid/out_ready, ALUCtrl, SrcA, SrcB, Shmat, out_dst, out_wr_en, out_is_load
//                 registered ALU operands and passed-along control
//   stall_cnt     saturating count of hazard stall cycles
interface ex_operand_stage_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_alu_ctrl;
    logic [4:0]       in_rs;
    logic [4:0]       in_rt;
    logic [31:0]      in_rs_data;
    logic [31:0]      in_rt_data;
    logic [31:0]      in_imm;
    logic             in_use_imm;
    logic [4:0]       in_shamt;
    logic [4:0]       in_dst;
    logic             in_wr_en;
    logic             in_is_load;
    logic             flush;
    logic [4:0]       mem_dst;
    logic             mem_wr_en;
    logic             mem_is_load;
    logic [31:0]      mem_data;
    logic [4:0]       wb_dst;
    logic             wb_wr_en;
    logic [31:0]      wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       ALUCtrl;
    logic [31:0]      SrcA;
    logic [31:0]      SrcB;
    logic [4:0]       Shmat;
    logic [4:0]       out_dst;
    logic             out_wr_en;
    logic             out_is_load;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output in_valid, in_alu_ctrl, in_rs, in_rt, in_rs_data, in_rt_data, in_imm,
               in_use_imm, in_shamt, in_dst, in_wr_en, in_is_load, flush,
               mem_dst, mem_wr_en, mem_is_load, mem_data, wb_dst, wb_wr_en, wb_data,
               out_ready,
        input  in_ready, out_valid, ALUCtrl, SrcA, SrcB, Shmat, out_dst, out_wr_en,
               out_is_load, stall_cnt
    );

    modport slave (
        input  in_valid, in_alu_ctrl, in_rs, in_rt, in_rs_data, in_rt_data, in_imm,
               in_use_imm, in_shamt, in_dst, in_wr_en, in_is_load, flush,
               mem_dst, mem_wr_en, mem_is_load, mem_data, wb_dst, wb_wr_en, wb_data,
               out_ready,
        output in_ready, out_valid, ALUCtrl, SrcA, SrcB, Shmat, out_dst, out_wr_en,
               out_is_load, stall_cnt
    );
endinterface

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX operand stage with hazard resolution ahead of the ALU
//
// Build option: EX_FORWARD_EN
//   defined   - forward from EX/MEM (non-load) and MEM/WB, interlock only on load-use
//   undefined - full interlock against EX, EX/MEM and MEM/WB, operands from register file
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, clears every output
//   bus    ex_operand_stage_if.slave: decode handshake, writeback info, ALU operands,
//          stall_cnt
module ex_operand_stage #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    ex_operand_stage_if.slave bus
);

    // A source only ever matches a real, written, nonzero destination.
    function automatic logic src_match(input logic [4:0] src, input logic [4:0] dst,
                                       input logic en);
        return en && (src != 5'd0) && (src == dst);
    endfunction

    // rs is always read; rt only when the immediate does not replace it.
    function automatic logic pair_match(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic rt_used, input logic [4:0] dst,
                                        input logic en);
        return src_match(rs, dst, en) || (rt_used && src_match(rt, dst, en));
    endfunction

    logic        adv;
    logic        rt_used;
    logic        hazard_raw;
    logic        hazard;
    logic        accept;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    assign adv     = bus.out_ready | ~bus.out_valid;
    assign rt_used = ~bus.in_use_imm;

`ifdef EX_FORWARD_EN
    logic mem_fwd_en;
    assign mem_fwd_en = bus.mem_wr_en & ~bus.mem_is_load;

    // Only a load still in EX or EX/MEM has no value to forward yet.
    assign hazard_raw =
        pair_match(bus.in_rs, bus.in_rt, rt_used, bus.out_dst,
                   bus.out_valid & bus.out_wr_en & bus.out_is_load) |
        pair_match(bus.in_rs, bus.in_rt, rt_used, bus.mem_dst,
                   bus.mem_wr_en & bus.mem_is_load);

    always_comb begin
        rs_val = bus.in_rs_data;
        if (src_match(bus.in_rs, bus.mem_dst, mem_fwd_en)) begin
            rs_val = bus.mem_data;
        end else if (src_match(bus.in_rs, bus.wb_dst, bus.wb_wr_en)) begin
            rs_val = bus.wb_data;
        end
        rt_val = bus.in_rt_data;
        if (src_match(bus.in_rt, bus.mem_dst, mem_fwd_en)) begin
            rt_val = bus.mem_data;
        end else if (src_match(bus.in_rt, bus.wb_dst, bus.wb_wr_en)) begin
            rt_val = bus.wb_data;
        end
    end
`else
    // No bypass paths: any pending write to a source blocks until it has retired.
    assign hazard_raw =
        pair_match(bus.in_rs, bus.in_rt, rt_used, bus.out_dst,
                   bus.out_valid & bus.out_wr_en) |
        pair_match(bus.in_rs, bus.in_rt, rt_used, bus.mem_dst, bus.mem_wr_en) |
        pair_match(bus.in_rs, bus.in_rt, rt_used, bus.wb_dst, bus.wb_wr_en);

    assign rs_val = bus.in_rs_data;
    assign rt_val = bus.in_rt_data;

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{bus.mem_is_load, bus.mem_data, bus.wb_data};
`endif

    assign hazard = bus.in_valid & hazard_raw;

    // Gated by rst_n so the handshake also reads 0 while reset is held.
    assign bus.in_ready = rst_n & adv & ~hazard & ~bus.flush;
    assign accept       = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid   <= 1'b0;
            bus.out_wr_en   <= 1'b0;
            bus.out_is_load <= 1'b0;
            bus.ALUCtrl     <= 4'd0;
            bus.SrcA        <= 32'd0;
            bus.SrcB        <= 32'd0;
            bus.Shmat       <= 5'd0;
            bus.out_dst     <= 5'd0;
            bus.stall_cnt   <= '0;
        end else begin
            if (bus.flush) begin
                bus.out_valid   <= 1'b0;
                bus.out_wr_en   <= 1'b0;
                bus.out_is_load <= 1'b0;
            end else if (adv) begin
                if (accept) begin
                    bus.out_valid   <= 1'b1;
                    bus.out_wr_en   <= bus.in_wr_en;
                    bus.out_is_load <= bus.in_is_load;
                    bus.ALUCtrl     <= bus.in_alu_ctrl;
                    bus.SrcA        <= rs_val;
                    bus.SrcB        <= bus.in_use_imm ? bus.in_imm : rt_val;
                    bus.Shmat       <= bus.in_shamt;
                    bus.out_dst     <= bus.in_dst;
                end else begin
                    // Bubble: control cleared, datapath left as it was.
                    bus.out_valid   <= 1'b0;
                    bus.out_wr_en   <= 1'b0;
                    bus.out_is_load <= 1'b0;
                end
            end

            if (hazard && !bus.flush && !(&bus.stall_cnt)) begin
                bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - scoreboard bench for ex_operand_stage (both EX_FORWARD_EN builds)
module tb_ex_operand_stage;
    localparam int CNT_W = 16;
`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  alu;
        logic [31:0] srca;
        logic [31:0] srcb;
        logic [4:0]  shamt;
        logic [4:0]  dst;
        logic        wr_en;
        logic        is_load;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_stall = '0;
    exp_t             exp_q[$];

    ex_operand_stage_if #(.CNT_W(CNT_W)) bus ();
    ex_operand_stage #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] alu, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] sh, input logic [4:0] dst,
                                input logic wr, input logic ld);
        return {alu, a, b, sh, dst, wr, ld};
    endfunction

    // Monitor: every transfer out of the stage is checked against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got ALUCtrl=%h SrcA=%h with no expected entry",
                         bus.ALUCtrl, bus.SrcA);
            end else begin
                e = exp_q.pop_front();
                chk("out_fields", {bus.ALUCtrl, bus.SrcA, bus.SrcB, bus.Shmat, bus.out_dst,
                                   bus.out_wr_en, bus.out_is_load}, e);
            end
        end
    end

    task automatic clear_in();
        bus.in_valid = 0; bus.in_alu_ctrl = 0; bus.in_rs = 0; bus.in_rt = 0;
        bus.in_rs_data = 0; bus.in_rt_data = 0; bus.in_imm = 0; bus.in_use_imm = 0;
        bus.in_shamt = 0; bus.in_dst = 0; bus.in_wr_en = 0; bus.in_is_load = 0;
        bus.flush = 0; bus.mem_dst = 0; bus.mem_wr_en = 0; bus.mem_is_load = 0;
        bus.mem_data = 0; bus.wb_dst = 0; bus.wb_wr_en = 0; bus.wb_data = 0;
    endtask

    task automatic drive(input logic [3:0] alu, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] rs_data, input logic [31:0] rt_data,
                         input logic [31:0] imm, input logic use_imm, input logic [4:0] shamt,
                         input logic [4:0] dst, input logic wr_en, input logic is_load);
        bus.in_valid = 1; bus.in_alu_ctrl = alu; bus.in_rs = rs; bus.in_rt = rt;
        bus.in_rs_data = rs_data; bus.in_rt_data = rt_data; bus.in_imm = imm;
        bus.in_use_imm = use_imm; bus.in_shamt = shamt; bus.in_dst = dst;
        bus.in_wr_en = wr_en; bus.in_is_load = is_load;
    endtask

    // Waits (bounded) for acceptance, pushes the expected result, checks the stall count.
    task automatic wait_accept(input string name, input exp_t e, input int maxc, input int exp_n);
        int n = 0;
        bit ok = 0;
        while (!ok && n < maxc) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1;
                exp_q.push_back(e);
            end else begin
                n++;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 0;
        checks++;
        if (!ok || n != exp_n) begin
            errors++;
            $display("FAIL %s_accept: accepted=%0d after %0d stall cycles, required accept after %0d",
                     name, ok, n, exp_n);
        end
        if (ok) exp_stall = exp_stall + CNT_W'(n);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int k;
        clear_in();
        bus.out_ready = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {bus.out_valid, bus.out_wr_en, bus.out_is_load, bus.in_ready,
                              bus.ALUCtrl, bus.SrcA, bus.SrcB, bus.Shmat, bus.out_dst}, 0);
        chk("reset_stall_cnt", bus.stall_cnt, 0);

        // First acceptance on the first edge after release.
        rst_n = 1;
        bus.out_ready = 1;
        drive(4'b0010, 0, 0, 32'd5, 32'd7, 0, 0, 0, 0, 0, 0);
        wait_accept("basic", mk(4'd2, 32'd5, 32'd7, 0, 0, 0, 0), 4, 0);

        drive(4'b0110, 1, 2, 32'h10, 32'h20, 32'h1234, 1, 5'd7, 5'd8, 1, 0);
        wait_accept("imm", mk(4'h6, 32'h10, 32'h1234, 5'd7, 5'd8, 1, 0), 4, 0);

        // r8 is still in EX: non-load, so only the interlock build waits.
        drive(4'b0000, 8, 0, 32'h30, 32'h40, 0, 0, 0, 0, 0, 0);
        wait_accept("ex_dep", mk(4'h0, 32'h30, 32'h40, 0, 0, 0, 0), 4, FWD ? 0 : 1);
        chk("stall_after_ex_dep", bus.stall_cnt, exp_stall);

        // rt matches WB for three cycles.
        bus.wb_wr_en = 1; bus.wb_dst = 5; bus.wb_data = 32'hBB;
        drive(4'b0001, 0, 5, 32'h1, 32'h77, 0, 0, 0, 0, 0, 0);
        fork
            begin repeat (3) @(posedge clk); #1; bus.wb_wr_en = 0; end
            wait_accept("wb_rt", mk(4'h1, 32'h1, FWD ? 32'hBB : 32'h77, 0, 0, 0, 0), 8, FWD ? 0 : 3);
        join
        chk("stall_after_wb_rt", bus.stall_cnt, exp_stall);

        // rt matches WB but the immediate replaces it: never a hazard.
        bus.wb_wr_en = 1; bus.wb_dst = 5; bus.wb_data = 32'hBB;
        drive(4'b0001, 0, 5, 32'h1, 32'h77, 32'h99, 1, 0, 0, 0, 0);
        wait_accept("wb_rt_imm", mk(4'h1, 32'h1, 32'h99, 0, 0, 0, 0), 4, 0);
        bus.wb_wr_en = 0;

        // rs matches both EX/MEM and WB: EX/MEM wins when forwarding.
        bus.mem_wr_en = 1; bus.mem_dst = 3; bus.mem_data = 32'hAA;
        bus.wb_wr_en = 1; bus.wb_dst = 3; bus.wb_data = 32'hBB;
        drive(4'b0010, 3, 0, 32'h11, 32'h22, 0, 0, 0, 0, 0, 0);
        fork
            begin repeat (2) @(posedge clk); #1; bus.mem_wr_en = 0; bus.wb_wr_en = 0; end
            wait_accept("mem_prio", mk(4'h2, FWD ? 32'hAA : 32'h11, 32'h22, 0, 0, 0, 0), 8, FWD ? 0 : 2);
        join
        chk("stall_after_mem_prio", bus.stall_cnt, exp_stall);

        // Register 0 never matches.
        bus.mem_wr_en = 1; bus.mem_dst = 0; bus.wb_wr_en = 1; bus.wb_dst = 0;
        drive(4'b0010, 0, 0, 32'h11, 32'h22, 0, 0, 0, 0, 0, 0);
        wait_accept("r0", mk(4'h2, 32'h11, 32'h22, 0, 0, 0, 0), 4, 0);
        bus.mem_wr_en = 0; bus.wb_wr_en = 0;

        // Load to r4 then a dependent add; the load moves EX -> MEM -> WB by hand.
        drive(4'b0000, 0, 0, 32'h1000, 0, 32'h4, 1, 0, 5'd4, 1, 1);
        wait_accept("load", mk(4'h0, 32'h1000, 32'h4, 0, 5'd4, 1, 1), 4, 0);
        drive(4'b0010, 4, 0, 32'hDEAD, 32'h3, 0, 0, 0, 5'd10, 1, 0);
        fork
            begin
                @(posedge clk); #1;
                bus.mem_dst = 4; bus.mem_is_load = 1; bus.mem_wr_en = 1; bus.mem_data = 0;
                @(posedge clk); #1;
                bus.mem_wr_en = 0; bus.mem_is_load = 0;
                bus.wb_dst = 4; bus.wb_wr_en = 1; bus.wb_data = 32'hCC;
                repeat (2) @(posedge clk); #1;
                bus.wb_wr_en = 0;
            end
            wait_accept("load_use", mk(4'h2, FWD ? 32'hCC : 32'hDEAD, 32'h3, 0, 5'd10, 1, 0),
                        8, FWD ? 2 : 4);
        join
        chk("stall_after_load_use", bus.stall_cnt, exp_stall);

        // Drain, then hold the output with out_ready=0 and flush it.
        @(posedge clk); #1;
        bus.out_ready = 0;
        drive(4'h6, 0, 0, 32'h100, 32'h200, 0, 0, 5'd3, 5'd7, 1, 1);
        wait_accept("hold_load", mk(4'h6, 32'h100, 32'h200, 5'd3, 5'd7, 1, 1), 4, 0);
        drive(4'h1, 7, 0, 32'h1, 32'h2, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_outputs", {bus.out_valid, bus.ALUCtrl, bus.SrcA, bus.SrcB, bus.Shmat,
                                 bus.out_dst, bus.out_wr_en, bus.out_is_load},
                {1'b1, 4'h6, 32'h100, 32'h200, 5'd3, 5'd7, 1'b1, 1'b1});
            @(posedge clk); #1;
            exp_stall = exp_stall + CNT_W'(1);
        end
        bus.flush = 1;
        @(negedge clk);
        chk("flush_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        chk("flush_outputs", {bus.out_valid, bus.out_wr_en, bus.out_is_load, bus.SrcA},
            {1'b0, 1'b0, 1'b0, 32'h100});
        chk("stall_after_flush", bus.stall_cnt, exp_stall);
        bus.flush = 0;
        bus.in_valid = 0;
        void'(exp_q.pop_back());
        bus.out_ready = 1;
        @(posedge clk); #1;

        // Hold a load-use hazard until the counter saturates, then reset mid-stall.
        bus.out_ready = 0;
        drive(4'h3, 0, 0, 32'h55, 32'h66, 0, 0, 5'd1, 5'd9, 1, 1);
        wait_accept("sat_load", mk(4'h3, 32'h55, 32'h66, 5'd1, 5'd9, 1, 1), 4, 0);
        drive(4'h2, 9, 0, 32'h1, 32'h2, 0, 0, 0, 0, 0, 0);
        k = 65534 - int'(exp_stall);
        repeat (k) @(posedge clk);
        #1;
        chk("stall_fffe", bus.stall_cnt, 16'hFFFE);
        @(posedge clk); #1;
        chk("stall_ffff", bus.stall_cnt, 16'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_saturated", bus.stall_cnt, 16'hFFFF);
        #2;
        rst_n = 0;
        #1;
        chk("async_reset_outputs", {bus.out_valid, bus.out_wr_en, bus.out_is_load, bus.in_ready,
                                    bus.ALUCtrl, bus.SrcA, bus.SrcB, bus.Shmat, bus.out_dst}, 0);
        chk("async_reset_stall_cnt", bus.stall_cnt, 0);
        void'(exp_q.pop_back());
        clear_in();
        exp_stall = '0;
        @(posedge clk); #1;
        rst_n = 1;
        bus.out_ready = 1;

        drive(4'h7, 2, 3, 32'hA5A5A5A5, 32'h5A5A5A5A, 0, 0, 5'd31, 5'd31, 1, 0);
        wait_accept("after_reset", mk(4'h7, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd31, 5'd31, 1, 0), 4, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("stall_after_reset", bus.stall_cnt, exp_stall);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
